// File: rtl/buzzer_arbiter.sv
// Round-robin arbiter sharing one tone generator between two beep requesters.
// Plays the granted tone for dur ticks, then holds a silent gap before returning to idle.
module buzzer_arbiter #(
  parameter int TONE_W    = 22,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 27000,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [TONE_W-1:0] tone0,
  input  logic [TONE_W-1:0] tone1,
  input  logic [DUR_W-1:0]  dur0,
  input  logic [DUR_W-1:0]  dur1,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              busy,
  output logic [TONE_W-1:0] tone
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     presc, presc_nx;
  logic [DUR_W-1:0]  dcnt, dcnt_nx;
  logic [DUR_W-1:0]  dur_q, dur_nx;
  logic [GW-1:0]     gcnt, gcnt_nx;
  logic              last_q, last_nx;
  logic [1:0]        grant_nx, done_nx;
  logic              busy_nx;
  logic [TONE_W-1:0] tone_nx;
  logic              win;
  logic              wrap;
  logic              leave_play;

  assign wrap = (presc == PW'(TICK_DIV - 1));

  // last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      presc  <= '0;
      dcnt   <= '0;
      dur_q  <= '0;
      gcnt   <= '0;
      last_q <= 1'b1;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      tone   <= '0;
    end else begin
      state  <= state_nx;
      presc  <= presc_nx;
      dcnt   <= dcnt_nx;
      dur_q  <= dur_nx;
      gcnt   <= gcnt_nx;
      last_q <= last_nx;
      grant  <= grant_nx;
      done   <= done_nx;
      busy   <= busy_nx;
      tone   <= tone_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    presc_nx   = presc;
    dcnt_nx    = dcnt;
    dur_nx     = dur_q;
    gcnt_nx    = gcnt;
    last_nx    = last_q;
    grant_nx   = grant;
    done_nx    = 2'b00;
    busy_nx    = busy;
    tone_nx    = tone;
    win        = 1'b0;
    leave_play = 1'b0;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          win      = (req == 2'b11) ? ~last_q : req[1];
          last_nx  = win;
          grant_nx = win ? 2'b10 : 2'b01;
          dur_nx   = win ? dur1 : dur0;
          tone_nx  = win ? tone1 : tone0;
          if ((win ? dur1 : dur0) == '0) begin
            tone_nx = '0;
          end
          busy_nx  = 1'b1;
          presc_nx = '0;
          dcnt_nx  = '0;
          state_nx = PLAY;
        end
      end

      PLAY: begin
        // Completion is judged on the final prescaler wrap, so dcnt never exceeds dur-1.
        if ((req & grant) == 2'b00) begin
          leave_play = 1'b1;
        end else if ((dur_q == '0) || (wrap && (dcnt == dur_q - DUR_W'(1)))) begin
          done_nx    = grant;
          leave_play = 1'b1;
        end else begin
          presc_nx = wrap ? '0 : presc + PW'(1);
          if (wrap) begin
            dcnt_nx = dcnt + DUR_W'(1);
          end
        end
      end

      GAP: begin
        presc_nx = wrap ? '0 : presc + PW'(1);
        if (wrap) begin
          if (gcnt == GW'(GAP_TICKS - 1)) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end else begin
            gcnt_nx = gcnt + GW'(1);
          end
        end
      end

      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
        busy_nx  = 1'b0;
        tone_nx  = '0;
      end
    endcase

    if (leave_play) begin
      grant_nx = 2'b00;
      tone_nx  = '0;
      presc_nx = '0;
      gcnt_nx  = '0;
      if (GAP_TICKS == 0) begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end else begin
        state_nx = GAP;
      end
    end
  end

endmodule
